vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: number of host-waiting cycles after which the host write is forced ahead of the display.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- disp_req  in  1  display read request, one read per asserted cycle
- disp_addr  in  14  display address {V[6:0],H[6:0]}
- disp_valid  out  1  disp_data valid
- disp_data  out  3  read colour {R,G,B}
- disp_miss  out  1  pulse: a display request was dropped
- host_wr_req  in  1  host write request, held until ack
- host_addr  in  14  host address {V[6:0],H[6:0]}
- host_data  in  3  host colour
- host_ack  out  1  pulse: host request completed
- host_err  out  1  with host_ack: request rejected
- mem_addr  out  14  to single-port VRAM
- mem_we  out  1  VRAM write enable
- mem_wdata  out  3  VRAM write data
- mem_rdata  in  3  VRAM read data, valid the cycle after mem_addr presented

Function
REQ-003 SHALL perform at most one VRAM access per cycle; mem_addr, mem_we and mem_wdata SHALL be registered.
REQ-004 SHALL implement a registered FSM with states IDLE, DRD, HWR and HERR, evaluated each cycle from the current-cycle inputs.
REQ-005 Host eligibility SHALL require host_wr_req=1 and state not HWR/HERR, so the cycle after an ack never starts a new host grant.
REQ-006 Next-state priority SHALL be:
- HWR/HERR, if host eligible and (disp_req=0 or starve_cnt=STARVE_LIMIT);
- otherwise DRD, if disp_req=1;
- otherwise IDLE.
REQ-007 Host state SHALL be HERR if host_addr[13:7] > 95, else HWR.
REQ-008 starve_cnt SHALL be a saturating counter:
- increments each cycle host_wr_req=1 and the host is not granted;
- saturates at STARVE_LIMIT;
- clears on any host grant or when host_wr_req=0.
REQ-009 In HWR: mem_addr=host_addr, mem_wdata=host_data and mem_we=1, all sampled on the granting edge; host_ack=1 and host_err=0 for exactly that cycle.
REQ-010 In HERR: mem_we=0, host_ack=1 and host_err=1 for one cycle; VRAM is not written.
REQ-011 In DRD: mem_addr=disp_addr from the granting edge, mem_we=0.
REQ-012 For a display request granted in cycle N:
- disp_valid SHALL be 1 in cycle N+3;
- disp_data SHALL be mem_rdata registered at the end of N+2.
REQ-013 A display read with disp_addr[13:7] > 95 SHALL set mem_we=0, return disp_data=3'b000 with disp_valid at N+3, and never write.
REQ-014 When disp_req=1 in cycle N loses to a forced host grant, disp_miss SHALL be 1 in cycle N+1, and no disp_valid SHALL be generated for that request.
REQ-015 In IDLE: mem_we=0, and mem_addr holds its last value.
REQ-016 The display pipeline SHALL keep one read completing per cycle under back-to-back disp_req, with no bubbles except forced host grants.
REQ-017 host_ack, host_err, disp_miss and disp_valid SHALL each be single-cycle pulses per event.
REQ-018 The host port SHALL accept host_addr/host_data changes only while host_ack=0 (stable-until-ack); the block SHALL NOT buffer more than one host request.

Reset
REQ-019 While reset=0, state SHALL be IDLE and all outputs SHALL be 0: mem_addr=0, mem_we=0, mem_wdata=0, disp_valid=0, disp_data=0, disp_miss=0, host_ack=0, host_err=0. starve_cnt and the read pipeline SHALL also be 0.
REQ-020 Reset asserted mid-operation SHALL discard in-flight display reads (no late disp_valid) and any pending host request without ack.
REQ-021 The first grant SHALL occur in the first cycle after reset deasserts in which a request is present.

Verification
REQ-022 Host write, idle display: host_wr_req=1, addr={7'd10,7'd20}, data=3'b101 -> next cycle mem_we=1, mem_addr=0x0514, host_ack=1, host_err=0; the following cycle has no grant despite held req.
REQ-023 Display stream: disp_req=1 for 4 cycles with addrs 0..3, VRAM preloaded 1,2,3,4 -> disp_valid high 4 consecutive cycles from N+3, disp_data 1,2,3,4.
REQ-024 Starvation: disp_req=1 continuously, host_wr_req=1, STARVE_LIMIT=8 -> host granted exactly after starve_cnt reaches 8, with one disp_miss pulse and one missing disp_valid.
REQ-025 Bad address: host_addr V=100 -> host_ack=1, host_err=1, mem_we=0 throughout, VRAM contents unchanged.
REQ-026 Reset mid-read: disp_req at N, reset=0 at N+1 for one cycle -> no disp_valid at N+3, all outputs 0 during reset.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter between a streaming display reader
// and a host writer. The display normally wins; a host request that has
// waited STARVE_LIMIT cycles is forced ahead, dropping that cycle's display
// read (flagged on disp_miss). Rows with V > 95 are outside the visible
// frame: host writes there are rejected, display reads there return black.
module vram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  // display read port
  input  logic        disp_req,
  input  logic [13:0] disp_addr,
  output logic        disp_valid,
  output logic [2:0]  disp_data,
  output logic        disp_miss,
  // host write port
  input  logic        host_wr_req,
  input  logic [13:0] host_addr,
  input  logic [2:0]  host_data,
  output logic        host_ack,
  output logic        host_err,
  // VRAM port
  output logic [13:0] mem_addr,
  output logic        mem_we,
  output logic [2:0]  mem_wdata,
  input  logic [2:0]  mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [6:0] V_LAST = 7'd95;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRD  = 2'd1;
  localparam logic [1:0] S_HWR  = 2'd2;
  localparam logic [1:0] S_HERR = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic [13:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [2:0]  mem_wdata_q, mem_wdata_d;

  logic        disp_miss_q, disp_miss_d;

  // Read pipeline: stage 1 = address on VRAM, stage 2 = data returning.
  logic        rd1_q, rd1_d;
  logic        bad1_q, bad1_d;
  logic        rd2_q;
  logic        bad2_q;
  logic        disp_valid_q;
  logic [2:0]  disp_data_q, disp_data_d;

  logic host_busy;
  logic host_elig;
  logic starve_hit;
  logic host_grant;
  logic host_bad;
  logic disp_bad;

  assign host_busy  = (state_q == S_HWR) || (state_q == S_HERR);
  assign host_elig  = host_wr_req && !host_busy;
  assign starve_hit = (starve_cnt_q == STARVE_MAX);
  assign host_grant = host_elig && (!disp_req || starve_hit);
  assign host_bad   = (host_addr[13:7] > V_LAST);
  assign disp_bad   = (disp_addr[13:7] > V_LAST);

  // Next-state arbitration: forced/idle-display host, else display, else idle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = S_IDLE;
    disp_miss_d = 1'b0;
    if (host_grant) begin
      state_d     = host_bad ? S_HERR : S_HWR;
      disp_miss_d = disp_req;
    end else if (disp_req) begin
      state_d = S_DRD;
    end
  end

  // Starvation counter: counts ungranted host-waiting cycles, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!host_wr_req || host_grant) begin
      starve_cnt_d = '0;
    end else if (!starve_hit) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // VRAM command for the cycle being granted; address holds when not accessing.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    case (state_d)
      S_HWR: begin
        mem_addr_d  = host_addr;
        mem_we_d    = 1'b1;
        mem_wdata_d = host_data;
      end
      S_DRD: begin
        mem_addr_d = disp_addr;
      end
      default: begin
        mem_we_d = 1'b0;
      end
    endcase
  end

  // Read pipeline inputs and returned colour (out-of-frame rows read as black).
  always_comb begin
    rd1_d       = (state_d == S_DRD);
    bad1_d      = (state_d == S_DRD) && disp_bad;
    disp_data_d = 3'b000;
    if (rd2_q && !bad2_q) begin
      disp_data_d = mem_rdata;
    end
  end

  // FSM, counter and VRAM command registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      disp_miss_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_miss_q  <= disp_miss_d;
    end
  end

  // Display read pipeline; reset flushes in-flight reads so none complete late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd1_q        <= 1'b0;
      bad1_q       <= 1'b0;
      rd2_q        <= 1'b0;
      bad2_q       <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      rd1_q        <= rd1_d;
      bad1_q       <= bad1_d;
      rd2_q        <= rd1_q;
      bad2_q       <= bad1_q;
      disp_valid_q <= rd2_q;
      disp_data_q  <= disp_data_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign disp_miss  = disp_miss_q;
  assign host_ack   = host_busy;
  assign host_err   = (state_q == S_HERR);

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: behavioural VRAM, display-data scoreboard and
// one task per scenario. Inputs change and outputs are sampled on negedges.
module tb_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        disp_req;
  logic [13:0] disp_addr;
  logic        disp_valid;
  logic [2:0]  disp_data;
  logic        disp_miss;
  logic        host_wr_req;
  logic [13:0] host_addr;
  logic [2:0]  host_data;
  logic        host_ack;
  logic        host_err;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [2:0] vram [0:16383];
  logic [2:0] exp_q [$];

  vram_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_valid  (disp_valid),
    .disp_data   (disp_data),
    .disp_miss   (disp_miss),
    .host_wr_req (host_wr_req),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .host_ack    (host_ack),
    .host_err    (host_err),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read VRAM: data for the address presented appears next cycle.
  always @(posedge clk) begin
    mem_rdata <= vram[mem_addr];
    if (mem_we) vram[mem_addr] = mem_wdata;
  end

  // Scoreboard: every disp_valid must match the oldest expected colour.
  always @(negedge clk) begin
    if (disp_valid === 1'b1) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL disp_valid_unexpected: got valid=1 data=%0d, required no valid", disp_data);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (disp_data !== e) begin
          errors = errors + 1;
          $display("FAIL disp_data: got %0d, required %0d", disp_data, e);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks = checks + 1;
    if ({mem_addr, mem_we, mem_wdata, disp_valid, disp_data, disp_miss, host_ack, host_err} !== 25'd0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: got addr=%h we=%b wd=%0d dv=%b dd=%0d miss=%b ack=%b err=%b, required all 0",
               mem_addr, mem_we, mem_wdata, disp_valid, disp_data, disp_miss, host_ack, host_err);
    end
    // Release reset with a host request already present: granted immediately.
    reset = 1'b1;
    host_wr_req = 1'b1;
    host_addr = {7'd1, 7'd1};
    host_data = 3'd3;
    step();
    checks = checks + 1;
    if ({host_ack, mem_we, mem_addr} !== {1'b1, 1'b1, 14'h0081}) begin
      errors = errors + 1;
      $display("FAIL first_grant: got ack=%b we=%b addr=%h, required ack=1 we=1 addr=0081", host_ack, mem_we, mem_addr);
    end
    host_wr_req = 1'b0;
    step();
  endtask

  task automatic test_host_write();
    host_wr_req = 1'b1;
    host_addr = {7'd10, 7'd20};
    host_data = 3'b101;
    step();
    checks = checks + 1;
    if ({mem_we, mem_addr, mem_wdata, host_ack, host_err} !== {1'b1, 14'h0514, 3'b101, 1'b1, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL host_write: got we=%b addr=%h wd=%0d ack=%b err=%b, required we=1 addr=0514 wd=5 ack=1 err=0",
               mem_we, mem_addr, mem_wdata, host_ack, host_err);
    end
    step();  // request still held through the ack cycle
    checks = checks + 1;
    if ({mem_we, host_ack} !== 2'b00) begin
      errors = errors + 1;
      $display("FAIL host_no_regrant: got we=%b ack=%b, required 0 0", mem_we, host_ack);
    end
    host_wr_req = 1'b0;
    step();
    checks = checks + 1;
    if (vram[14'h0514] !== 3'b101) begin
      errors = errors + 1;
      $display("FAIL host_vram: got %0d, required 5", vram[14'h0514]);
    end
  endtask

  task automatic test_disp_stream();
    for (int i = 0; i < 4; i++) vram[i] = 3'(i + 1);
    for (int k = 0; k < 8; k++) begin
      step();
      checks = checks + 1;
      if (disp_valid !== (k >= 3 && k <= 6)) begin
        errors = errors + 1;
        $display("FAIL stream_valid k=%0d: got %b, required %b", k, disp_valid, (k >= 3 && k <= 6));
      end
      disp_req = (k < 4);
      disp_addr = 14'(k);
      if (k < 4) exp_q.push_back(3'(k + 1));
    end
    disp_req = 1'b0;
  endtask

  task automatic test_starvation();
    int misses = 0;
    int acks = 0;
    for (int i = 0; i < 16; i++) vram[16 + i] = 3'((i % 7) + 1);
    for (int k = 0; k < 19; k++) begin
      step();
      if (k > 0) begin
        checks = checks + 1;
        if (disp_valid !== (k >= 3 && k != 11 && k <= 17)) begin
          errors = errors + 1;
          $display("FAIL starve_valid k=%0d: got %b, required %b", k, disp_valid, (k >= 3 && k != 11 && k <= 17));
        end
        checks = checks + 1;
        if ({host_ack, disp_miss} !== {(k == 9), (k == 9)}) begin
          errors = errors + 1;
          $display("FAIL starve_grant k=%0d: got ack=%b miss=%b, required %b %b", k, host_ack, disp_miss, (k == 9), (k == 9));
        end
      end
      if (host_ack) acks++;
      if (disp_miss) misses++;
      if (k == 0) begin
        host_wr_req = 1'b1;
        host_addr = {7'd1, 7'd0};
        host_data = 3'd6;
      end
      if (k == 9) host_wr_req = 1'b0;
      disp_req = (k < 15);
      disp_addr = 14'(16 + (k % 16));
      if (k < 15 && k != 8) exp_q.push_back(vram[16 + (k % 16)]);
    end
    disp_req = 1'b0;
    checks = checks + 1;
    if ({acks, misses} !== {32'd1, 32'd1}) begin
      errors = errors + 1;
      $display("FAIL starve_counts: got acks=%0d misses=%0d, required 1 1", acks, misses);
    end
    checks = checks + 1;
    if (vram[14'h0080] !== 3'd6) begin
      errors = errors + 1;
      $display("FAIL starve_vram: got %0d, required 6", vram[14'h0080]);
    end
  endtask

  task automatic test_bad_addr();
    logic [13:0] a;
    a = {7'd100, 7'd5};
    vram[a] = 3'd2;
    host_wr_req = 1'b1;
    host_addr = a;
    host_data = 3'd7;
    for (int k = 1; k < 4; k++) begin
      step();
      checks = checks + 1;
      if (mem_we !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL bad_host_we k=%0d: got %b, required 0", k, mem_we);
      end
      if (k == 1) begin
        checks = checks + 1;
        if ({host_ack, host_err} !== 2'b11) begin
          errors = errors + 1;
          $display("FAIL bad_host_ack: got ack=%b err=%b, required 1 1", host_ack, host_err);
        end
        host_wr_req = 1'b0;
      end
    end
    checks = checks + 1;
    if (vram[a] !== 3'd2) begin
      errors = errors + 1;
      $display("FAIL bad_host_vram: got %0d, required 2", vram[a]);
    end
    // Display read of an out-of-frame row returns black after three cycles.
    vram[a] = 3'd5;
    disp_req = 1'b1;
    disp_addr = a;
    exp_q.push_back(3'd0);
    for (int k = 1; k < 5; k++) begin
      step();
      disp_req = 1'b0;
      checks = checks + 1;
      if ({disp_valid, mem_we} !== {(k == 3), 1'b0}) begin
        errors = errors + 1;
        $display("FAIL bad_disp k=%0d: got valid=%b we=%b, required %b 0", k, disp_valid, mem_we, (k == 3));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    vram[5] = 3'd4;
    disp_req = 1'b1;
    disp_addr = 14'd5;
    step();
    disp_req = 1'b0;
    reset = 1'b0;
    #1;
    checks = checks + 1;
    if ({mem_addr, mem_we, mem_wdata, disp_valid, disp_data, disp_miss, host_ack, host_err} !== 25'd0) begin
      errors = errors + 1;
      $display("FAIL midreset_outputs: got addr=%h we=%b wd=%0d dv=%b dd=%0d miss=%b ack=%b err=%b, required all 0",
               mem_addr, mem_we, mem_wdata, disp_valid, disp_data, disp_miss, host_ack, host_err);
    end
    step();
    reset = 1'b1;
    for (int k = 2; k < 6; k++) begin
      step();
      checks = checks + 1;
      if (disp_valid !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL midreset_valid k=%0d: got 1, required 0", k);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    disp_req = 1'b0;
    disp_addr = '0;
    host_wr_req = 1'b0;
    host_addr = '0;
    host_data = '0;
    for (int i = 0; i < 16384; i++) vram[i] = 3'd0;

    test_reset();
    test_host_write();
    test_disp_stream();
    test_starvation();
    test_bad_addr();
    test_reset_mid_read();

    step();
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: got %0d reads outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
